if_id_pipe_reg: RTL
===================

Name: if_id_pipe_reg

Overview:
- Parametrised IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer, so fetch can stall without a combinational ready path back through decode.
- Adds three things: flush (branch/jump squash) that loads a NOP bubble, independent widths for instruction and PC, and a saturating bubble-cycle counter for performance monitoring.
- Sits between instruction fetch and decode. All outputs come from registers.

Parameters:
INSTR_WIDTH, 32, instruction word width
PC_WIDTH, 32, PC-result width
NOP_INSTR, 32'h00000000, instruction word presented while the stage holds no valid data (width INSTR_WIDTH)
CNT_WIDTH, 16, width of BubbleCount

Ports:
Clock  in  1  rising-edge clock; all state updates on posedge
Reset_n  in  1  asynchronous, active-low reset
InValid  in  1  fetch presents a valid instruction/PC
InReady  out  1  stage can accept; transfer when InValid&InReady
InstructionIn  in  INSTR_WIDTH  fetched instruction
PCResultIn  in  PC_WIDTH  PC+4 from fetch
OutValid  out  1  InstructionOut/PCResultOut valid for decode
OutReady  in  1  decode accepts; transfer when OutValid&OutReady
InstructionOut  out  INSTR_WIDTH  instruction to decode
PCResultOut  out  PC_WIDTH  PC+4 to decode
Flush  in  1  synchronous squash of all held entries
CountClear  in  1  synchronous clear of BubbleCount
BubbleCount  out  CNT_WIDTH  saturating count of cycles with OutValid=0

Behaviour:
- Definitions: in_fire = InValid & InReady; out_fire = OutValid & OutReady.
- Storage: main register (drives outputs) and skid register. State is one of EMPTY, ONE, TWO.
- Output decode: OutValid = (state != EMPTY); InReady = (state != TWO). Both are decoded from the state register only, with no combinational path from InValid or OutReady.
- Reset (Reset_n=0, async): state=EMPTY, OutValid=0, InReady=1, InstructionOut=NOP_INSTR, PCResultOut=0, BubbleCount=0, skid cleared. The first posedge after Reset_n rises may accept data.
- Latency: data accepted at edge N appears on the outputs after edge N (1 cycle) when the stage was EMPTY, or when it was ONE and out_fire occurred in the same cycle.
- Transitions (no Flush):
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE: in_fire & !out_fire -> TWO, skid<=in, main holds. !in_fire & out_fire -> EMPTY, main<=NOP_INSTR/PC 0. Both -> ONE, main<=in. Neither -> hold.
  - TWO: out_fire -> ONE, main<=skid. No in_fire is possible (InReady=0). No out_fire -> hold.
- Ordering: strict FIFO order is preserved and no data is ever dropped or duplicated without Flush.
- Flush: highest priority. At the posedge with Flush=1: state->EMPTY, main<=NOP_INSTR/PC 0, skid discarded, and any in_fire or out_fire that cycle has no storage effect. Decode must treat an out_fire coincident with Flush as squashed. InReady returns to 1 the next cycle.
- Held data stays stable while OutValid=1 and OutReady=0.
- BubbleCount:
  - Each posedge with OutValid=0 (sampled pre-edge) increments it, saturating at 2^CNT_WIDTH-1.
  - CountClear=1 sets it to 0 and takes priority over increment.
  - Flush does not affect it.
- Reset asserted mid-operation: immediate (async) return to reset values, with no wait for a clock edge.

Test Plan:
1. Reset release, then InValid=1 with Instr=0x8C220004, PC=0x4, OutReady=1 -> after 1 edge OutValid=1, outputs 0x8C220004/0x4; back-to-back stream 0x4,0x8,0xC appears one per cycle with InReady held at 1.
2. OutReady=0, feed 0x11111111 (PC 0x4) then 0x22222222 (PC 0x8) -> state TWO, InReady=0, outputs hold 0x11111111. Raise OutReady -> 0x11111111 then 0x22222222 in order, InReady=1 after the first out_fire.
3. In state TWO assert Flush with InValid=1 -> next cycle OutValid=0, InstructionOut=NOP_INSTR, PCResultOut=0, InReady=1; the flushed-cycle input never appears.
4. ONE with simultaneous in_fire and out_fire (0xA then 0xB) -> state stays ONE, outputs 0xB next cycle, no bubble.
5. CNT_WIDTH=4, InValid=0 for 20 cycles -> BubbleCount reaches 15 and holds. CountClear=1 for one cycle -> 0, then resumes counting.
6. Assert Reset_n=0 between edges while in TWO -> outputs go to reset values immediately, before the next posedge.

Source files
------------

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with a valid/ready handshake, a 2-entry skid buffer,
// flush-to-bubble and a saturating bubble-cycle counter. All outputs are flops.
module if_id_pipe_reg #(
  parameter int unsigned              INSTR_WIDTH = 32,
  parameter int unsigned              PC_WIDTH    = 32,
  parameter logic [INSTR_WIDTH-1:0]   NOP_INSTR   = '0,
  parameter int unsigned              CNT_WIDTH   = 16
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [INSTR_WIDTH-1:0] InstructionIn,
  input  logic [PC_WIDTH-1:0]    PCResultIn,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [INSTR_WIDTH-1:0] InstructionOut,
  output logic [PC_WIDTH-1:0]    PCResultOut,
  input  logic                   Flush,
  input  logic                   CountClear,
  output logic [CNT_WIDTH-1:0]   BubbleCount
);

  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] main_instr_q, main_instr_d;
  logic [PC_WIDTH-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0]    skid_pc_q, skid_pc_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   in_fire;
  logic                   out_fire;

  // State and data registers; handshake flags are registered copies of the next state decode.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= EMPTY;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state, data steering and bubble counter.
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    cnt_d        = cnt_q;
    in_fire      = InValid & in_ready_q;
    out_fire     = out_valid_q & OutReady;

    if (Flush) begin
      state_d      = EMPTY;
      main_instr_d = NOP_INSTR;
      main_pc_d    = '0;
      skid_instr_d = NOP_INSTR;
      skid_pc_d    = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            main_instr_d = InstructionIn;
            main_pc_d    = PCResultIn;
          end
        end
        ONE: begin
          unique case ({in_fire, out_fire})
            2'b10: begin
              state_d      = TWO;
              skid_instr_d = InstructionIn;
              skid_pc_d    = PCResultIn;
            end
            2'b01: begin
              state_d      = EMPTY;
              main_instr_d = NOP_INSTR;
              main_pc_d    = '0;
            end
            2'b11: begin
              main_instr_d = InstructionIn;
              main_pc_d    = PCResultIn;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (out_fire) begin
            state_d      = ONE;
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);

    // Clear wins over increment; flush leaves the counter alone.
    if (CountClear) begin
      cnt_d = '0;
    end else if (!out_valid_q && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  assign OutValid       = out_valid_q;
  assign InReady        = in_ready_q;
  assign InstructionOut = main_instr_q;
  assign PCResultOut    = main_pc_q;
  assign BubbleCount    = cnt_q;

endmodule
